// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package dmem_pkg;

    localparam int DMEM_DEPTH_DEF = 1024;
    localparam int DMEM_WAIT_DEF  = 1;
    localparam int WORD_W         = 32;
    localparam int STRB_W         = WORD_W / 8;
    localparam int CNT_W          = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Backing store: DEPTH x 32-bit words, per-byte write enables, registered read port.
// Latency: write and read both take effect on the rising edge where we/re is high.
// Backpressure: none; the owner decides when to access.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     idx,
    input  logic [WORD_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    output logic [WORD_W-1:0] rdata
);

    // Storage is intentionally left without reset so contents survive rst.
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    // Byte-masked write and registered read on the same access edge.
    always_ff @(posedge clk) begin
        for (int b = 0; b < STRB_W; b++) begin
            if (we && wstrb[b]) begin
                mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (re) begin
            rdata_q <= mem_q[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder (IDLE/WAIT/RESP) with optional error check (DMEM_ERR_EN).
// Latency: access commits WAIT_CYCLES edges after acceptance; resp_valid is high from that edge on.
// Backpressure: req_ready only in IDLE; response held stable in RESP until resp_ready.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = DMEM_DEPTH_DEF,
    parameter int WAIT_CYCLES = DMEM_WAIT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam bit NO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [CNT_W-1:0] CNT_LOAD = NO_WAIT ? '0 : CNT_W'(WAIT_CYCLES - 1);

    dmem_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              live_q;      // low until the first edge after reset release
    logic              we_q, err_q;
    logic [AW-1:0]     idx_q;
    logic [WORD_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;

    logic              accept, commit, req_err;
    logic              eff_we, eff_err;
    logic [AW-1:0]     eff_idx;
    logic [WORD_W-1:0] eff_wdata, arr_rdata;
    logic [STRB_W-1:0] eff_wstrb;

    assign req_ready = live_q && (state_q == IDLE);
    assign accept    = req_valid && req_ready;

`ifdef DMEM_ERR_EN
    // Misaligned or beyond the end of the store.
    assign req_err = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);
`else
    // Address wraps: byte offset and bits above the index are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};
    assign req_err = 1'b0;
`endif

    // With no wait states the access commits on the acceptance edge, so it
    // must use the live request; otherwise it uses the latched copy.
    assign eff_we    = (state_q == IDLE) ? req_we               : we_q;
    assign eff_err   = (state_q == IDLE) ? req_err              : err_q;
    assign eff_idx   = (state_q == IDLE) ? req_addr[AW+1:2]     : idx_q;
    assign eff_wdata = (state_q == IDLE) ? req_wdata            : wdata_q;
    assign eff_wstrb = (state_q == IDLE) ? req_wstrb            : wstrb_q;

    // Next-state and commit strobe; the commit edge is the one entering RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (NO_WAIT) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter and request latches; latches load only on acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            live_q  <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            live_q  <= 1'b1;
            if (accept) begin
                we_q    <= req_we;
                err_q   <= req_err;
                idx_q   <= req_addr[AW+1:2];
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
            end
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (commit && eff_we && !eff_err),
        .re    (commit && !eff_we && !eff_err),
        .idx   (eff_idx),
        .wdata (eff_wdata),
        .wstrb (eff_wstrb),
        .rdata (arr_rdata)
    );

    // The array read register only changes on a load commit, so the
    // response stays stable for as long as the FSM sits in RESP.
    assign resp_valid = (state_q == RESP);
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = (resp_valid && !we_q && !err_q) ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: WAIT_CYCLES=1 instance for most scenarios, WAIT_CYCLES=0 for streaming.
// Latency: n/a.
// Backpressure: n/a.
module tb_dmem_responder;

    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // WAIT_CYCLES=1 instance
    logic        req_valid = 0, req_we = 0, resp_ready = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic [3:0]  req_wstrb = 0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    // WAIT_CYCLES=0 instance
    logic        b_req_valid = 0, b_req_we = 0, b_resp_ready = 0;
    logic [31:0] b_req_addr = 0, b_req_wdata = 0;
    logic [3:0]  b_req_wstrb = 0;
    logic        b_req_ready, b_resp_valid, b_resp_err;
    logic [31:0] b_resp_rdata;

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
    );

    // One full transaction on the WAIT_CYCLES=1 instance. lat counts falling
    // edges after the acceptance edge until resp_valid is seen (-1 = timeout),
    // so lat = WAIT_CYCLES+1 means resp_valid is first sampled at edge N+1+WAIT_CYCLES.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, output logic [31:0] rdata, output logic err,
                       output int lat);
        int n;
        @(negedge clk);
        req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = strb; req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = -1; rdata = '0; err = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        if (lat > 0) begin
            rdata = resp_rdata;
            err   = resp_err;
            resp_ready = 1'b1;
            @(posedge clk); #1;
            resp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++; if (req_ready !== 1'b0) $display("FAIL rst_req_ready: got %b want 0", req_ready); else pass_cnt++;
        total_cnt++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid: got %b want 0", resp_valid); else pass_cnt++;
        total_cnt++; if (resp_rdata !== 32'h0) $display("FAIL rst_resp_rdata: got %h want 0", resp_rdata); else pass_cnt++;
        total_cnt++; if (resp_err !== 1'b0) $display("FAIL rst_resp_err: got %b want 0", resp_err); else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++; if (req_ready !== 1'b0) $display("FAIL rel_before_edge: got %b want 0", req_ready); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (req_ready !== 1'b1) $display("FAIL rel_after_edge: got %b want 1", req_ready); else pass_cnt++;
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat;
        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
        total_cnt++; if (lat !== 2) $display("FAIL st_latency: got %0d want 2", lat); else pass_cnt++;
        total_cnt++; if (rd !== 32'h0 || er !== 1'b0) $display("FAIL st_resp: got %h/%b want 0/0", rd, er); else pass_cnt++;
        txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        total_cnt++; if (lat !== 2) $display("FAIL ld_latency: got %0d want 2", lat); else pass_cnt++;
        total_cnt++; if (rd !== 32'hDEADBEEF) $display("FAIL ld_data: got %h want deadbeef", rd); else pass_cnt++;
        total_cnt++; if (er !== 1'b0) $display("FAIL ld_err: got %b want 0", er); else pass_cnt++;
    endtask

    task automatic test_strobe();
        logic [31:0] rd; logic er; int lat;
        txn(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
        txn(1'b1, 32'h20, 32'h000000AA, 4'h1, rd, er, lat);
        txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        total_cnt++; if (rd !== 32'h112233AA) $display("FAIL strb_byte0: got %h want 112233aa", rd); else pass_cnt++;
        txn(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, rd, er, lat);
        total_cnt++; if (lat !== 2) $display("FAIL strb_zero_resp: got lat %0d want 2", lat); else pass_cnt++;
        txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        total_cnt++; if (rd !== 32'h112233AA) $display("FAIL strb_zero_mem: got %h want 112233aa", rd); else pass_cnt++;
        txn(1'b1, 32'h20, 32'h55667788, 4'hA, rd, er, lat);
        txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        total_cnt++; if (rd !== 32'h552277AA) $display("FAIL strb_mixed: got %h want 552277aa", rd); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat; int n;
        @(negedge clk);
        req_we = 1'b0; req_addr = 32'h10; req_valid = 1'b1; resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (resp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total_cnt++; if (resp_valid !== 1'b1) $display("FAIL bp_wait: resp_valid %b want 1", resp_valid); else pass_cnt++;
        // Competing store that must be ignored while the response is pending.
        req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_wstrb = 4'hF; req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total_cnt++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF || resp_err !== 1'b0 || req_ready !== 1'b0)
                $display("FAIL bp_hold[%0d]: got v=%b d=%h e=%b rdy=%b want 1/deadbeef/0/0",
                         i, resp_valid, resp_rdata, resp_err, req_ready);
            else pass_cnt++;
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        total_cnt++; if (resp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL bp_release: got v=%b rdy=%b want 0/1", resp_valid, req_ready); else pass_cnt++;
        txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        total_cnt++; if (rd !== 32'hDEADBEEF) $display("FAIL bp_ignored_store: got %h want deadbeef", rd); else pass_cnt++;
    endtask

    task automatic test_early_ready();
        int lat;
        resp_ready = 1'b1;
        @(negedge clk);
        req_we = 1'b0; req_addr = 32'h20; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        total_cnt++; if (lat !== 2) $display("FAIL early_rdy_latency: got %0d want 2", lat); else pass_cnt++;
        total_cnt++; if (resp_rdata !== 32'h552277AA) $display("FAIL early_rdy_data: got %h want 552277aa", resp_rdata); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (resp_valid !== 1'b0) $display("FAIL early_rdy_drop: got %b want 0", resp_valid); else pass_cnt++;
        resp_ready = 1'b0;
    endtask

    task automatic test_addr_wrap();
        logic [31:0] rd; logic er; int lat;
        txn(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, er, lat);
`ifdef DMEM_ERR_EN
        txn(1'b1, 32'h3, 32'h12345678, 4'hF, rd, er, lat);
        total_cnt++; if (er !== 1'b1 || rd !== 32'h0 || lat !== 2)
            $display("FAIL err_misaligned: got e=%b d=%h lat=%0d want 1/0/2", er, rd, lat); else pass_cnt++;
        txn(1'b0, 32'h1000, 32'h0, 4'h0, rd, er, lat);
        total_cnt++; if (er !== 1'b1 || rd !== 32'h0 || lat !== 2)
            $display("FAIL err_range_load: got e=%b d=%h lat=%0d want 1/0/2", er, rd, lat); else pass_cnt++;
        txn(1'b1, 32'h1000, 32'h87654321, 4'hF, rd, er, lat);
        total_cnt++; if (er !== 1'b1) $display("FAIL err_range_store: got e=%b want 1", er); else pass_cnt++;
        txn(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
        total_cnt++; if (rd !== 32'hCAFEF00D || er !== 1'b0)
            $display("FAIL err_mem_intact: got %h/%b want cafef00d/0", rd, er); else pass_cnt++;
`else
        txn(1'b0, 32'h1000, 32'h0, 4'h0, rd, er, lat);
        total_cnt++; if (rd !== 32'hCAFEF00D || er !== 1'b0)
            $display("FAIL wrap_top: got %h/%b want cafef00d/0", rd, er); else pass_cnt++;
        txn(1'b0, 32'h13, 32'h0, 4'h0, rd, er, lat);
        total_cnt++; if (rd !== 32'hDEADBEEF || er !== 1'b0)
            $display("FAIL wrap_lowbits: got %h/%b want deadbeef/0", rd, er); else pass_cnt++;
        txn(1'b0, 32'h10000010, 32'h0, 4'h0, rd, er, lat);
        total_cnt++; if (rd !== 32'hDEADBEEF) $display("FAIL wrap_highbits: got %h want deadbeef", rd); else pass_cnt++;
`endif
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er; int lat;
        txn(1'b1, 32'h40, 32'h0BADF00D, 4'hF, rd, er, lat);
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'hFFFFFFFF; req_wstrb = 4'hF; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b0;   // FSM is in WAIT here, before the commit edge
        #1;
        total_cnt++; if (resp_valid !== 1'b0 || req_ready !== 1'b0)
            $display("FAIL abort_in_rst: got v=%b rdy=%b want 0/0", resp_valid, req_ready); else pass_cnt++;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        total_cnt++; if (req_ready !== 1'b1 || resp_valid !== 1'b0)
            $display("FAIL abort_release: got rdy=%b v=%b want 1/0", req_ready, resp_valid); else pass_cnt++;
        txn(1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
        total_cnt++; if (rd !== 32'h0BADF00D) $display("FAIL abort_no_write: got %h want 0badf00d", rd); else pass_cnt++;
    endtask

    task automatic set_item(input int k);
        if (k < 4) begin
            b_req_we = 1'b1; b_req_addr = 32'(4 * k); b_req_wdata = 32'hA5000000 + 32'(k); b_req_wstrb = 4'hF;
        end else begin
            b_req_we = 1'b0; b_req_addr = 32'(4 * (k - 4)); b_req_wdata = 32'h0; b_req_wstrb = 4'h0;
        end
    endtask

    task automatic test_back_to_back();
        int acc_e[8];
        int rsp_e[8];
        logic [31:0] rdat[8];
        int na, nr;
        logic acc;
        na = 0; nr = 0;
        b_resp_ready = 1'b1;
        set_item(0);
        b_req_valid = 1'b1;
        for (int c = 0; c < 60 && nr < 8; c++) begin
            @(negedge clk);
            acc = b_req_ready & b_req_valid;
            if (acc) acc_e[na] = edge_cnt + 1;
            if (b_resp_valid === 1'b1 && nr < 8) begin
                rsp_e[nr] = edge_cnt + 1;
                rdat[nr]  = b_resp_rdata;
                nr++;
            end
            @(posedge clk); #1;
            if (acc) begin
                na++;
                if (na < 8) set_item(na);
                else b_req_valid = 1'b0;
            end
        end
        b_req_valid = 1'b0;
        b_resp_ready = 1'b0;
        total_cnt++; if (nr !== 8 || na !== 8) $display("FAIL b2b_count: got acc=%0d rsp=%0d want 8/8", na, nr); else pass_cnt++;
        if (nr == 8 && na == 8) begin
            for (int i = 1; i < 8; i++) begin
                total_cnt++; if (acc_e[i] - acc_e[i-1] !== 2)
                    $display("FAIL b2b_spacing[%0d]: got %0d want 2", i, acc_e[i] - acc_e[i-1]); else pass_cnt++;
            end
            for (int i = 0; i < 8; i++) begin
                total_cnt++; if (rsp_e[i] - acc_e[i] !== 1)
                    $display("FAIL b2b_lag[%0d]: got %0d want 1", i, rsp_e[i] - acc_e[i]); else pass_cnt++;
            end
            for (int i = 0; i < 8; i++) begin
                total_cnt++;
                if (rdat[i] !== ((i < 4) ? 32'h0 : 32'hA5000000 + 32'(i - 4)))
                    $display("FAIL b2b_data[%0d]: got %h want %h", i, rdat[i],
                             (i < 4) ? 32'h0 : 32'hA5000000 + 32'(i - 4));
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_load();
        test_strobe();
        test_backpressure();
        test_early_ready();
        test_addr_wrap();
        test_reset_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
